// File: rtl/sync_down_counter.sv
// sync_down_counter
// Presettable synchronous binary down counter with terminal-count decode
// and an underflow pulse. Every q bit is updated from the same clock edge.
// On underflow the counter either reloads the most recent preset value
// or wraps to all-ones, chosen by auto_reload at the underflow edge.
module sync_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Last preset value, used as the reload target when auto_reload is set.
    logic [WIDTH-1:0] reload_reg;

    logic [WIDTH-1:0] q_next;
    logic             underflow_next;
    logic             q_is_zero;

    assign q_is_zero = (q == '0);

    // Next-count selection: load beats enable; enable at zero is the underflow step.
    always_comb begin
        q_next         = q;
        underflow_next = 1'b0;
        if (load) begin
            q_next = d;
        end else if (en) begin
            if (!q_is_zero) begin
                q_next = q - ONE;
            end else begin
                underflow_next = 1'b1;
                q_next         = auto_reload ? reload_reg : ALL_ONES;
            end
        end
    end

    // Count register and underflow pulse; async clear returns to all-ones.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q         <= ALL_ONES;
            underflow <= 1'b0;
        end else begin
            q         <= q_next;
            underflow <= underflow_next;
        end
    end

    // Preset capture; clearing also forgets any earlier preset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            reload_reg <= ALL_ONES;
        end else if (load) begin
            reload_reg <= d;
        end
    end

    // Terminal-count flag is a pure decode of the registered count.
    assign zero = q_is_zero;

endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter
// Directed bench for sync_down_counter (WIDTH=3). A behavioural model in
// plain integer arithmetic tracks the expected count, reload value and
// underflow pulse; a compare process checks every cycle, and hand-computed
// literal expectations along each scenario pin the model itself.
module tb_sync_down_counter;

    localparam int WIDTH = 3;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             clr_n;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 0;

    // model state
    int m_q   = MAXV;
    int m_rel = MAXV;
    int m_uf  = 0;

    sync_down_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .en          (en),
        .load        (load),
        .d           (d),
        .auto_reload (auto_reload),
        .q           (q),
        .zero        (zero),
        .underflow   (underflow)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a countdown that on reaching zero either restarts
    // from the last preset or from the maximum value.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_q   = MAXV;
            m_rel = MAXV;
            m_uf  = 0;
        end else if (load) begin
            m_q   = int'(d);
            m_rel = int'(d);
            m_uf  = 0;
        end else if (en && m_q == 0) begin
            m_uf = 1;
            m_q  = auto_reload ? m_rel : MAXV;
        end else begin
            if (en) m_q = (m_q + MAXV) % (MAXV + 1);
            m_uf = 0;
        end
    end

    // Per-cycle scoreboard compare, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (cmp_on) begin
            chk("model_q", int'(q), m_q);
            chk("model_zero", int'(zero), (m_q == 0) ? 1 : 0);
            chk("model_underflow", int'(underflow), m_uf);
        end
    end

    // driver: advance one clock, land 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int eq, input int ez, input int eu);
        chk({name, "_q"}, int'(q), eq);
        chk({name, "_zero"}, int'(zero), ez);
        chk({name, "_uf"}, int'(underflow), eu);
    endtask

    task automatic clr_pulse();
        clr_n = 1'b0;
        #2;
        clr_n = 1'b1;
    endtask

    int exp_wrap[9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
    int exp_ar[6]   = '{3, 2, 1, 0, 4, 3};
    int uf_count;

    initial begin
        clr_n = 1'b0; en = 1'b0; load = 1'b0; d = '0; auto_reload = 1'b0;
        tick();
        tick();
        expect_out("reset_state", 7, 0, 0);
        clr_n = 1'b1;
        cmp_on = 1'b1;

        // Reset mid-count at q=3 acts without a clock
        en = 1'b1;
        repeat (4) tick();
        chk("pre_reset_q", int'(q), 3);
        clr_n = 1'b0;
        #1;
        expect_out("async_clear", 7, 0, 0);
        tick();
        expect_out("held_clear", 7, 0, 0);
        clr_n = 1'b1;
        tick(); chk("after_rel_1", int'(q), 6);
        tick(); chk("after_rel_2", int'(q), 5);
        tick(); chk("after_rel_3", int'(q), 4);

        // Free-run wrap from 7
        en = 1'b0;
        clr_pulse();
        chk("wrap_start", int'(q), 7);
        auto_reload = 1'b0;
        en = 1'b1;
        uf_count = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            uf_count += int'(underflow);
            expect_out($sformatf("wrap_%0d", i), exp_wrap[i],
                       (exp_wrap[i] == 0) ? 1 : 0, (i == 7) ? 1 : 0);
        end
        chk("wrap_uf_count", uf_count, 1);

        // Load 4 then auto-reload countdown
        en = 1'b0; load = 1'b1; d = 3'd4;
        tick();
        expect_out("load4", 4, 0, 0);
        load = 1'b0; d = 3'd1;
        auto_reload = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_out($sformatf("autorl_%0d", i), exp_ar[i],
                       (exp_ar[i] == 0) ? 1 : 0, (i == 4) ? 1 : 0);
        end

        // Load and enable together: load wins
        tick();
        chk("to_two", int'(q), 2);
        load = 1'b1; d = 3'd5;
        tick();
        expect_out("load_en", 5, 0, 0);
        load = 1'b0; en = 1'b0; d = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("hold_%0d", i), 5, 0, 0);
        end

        // Zero reload value
        load = 1'b1; d = 3'd0;
        tick();
        expect_out("load0", 0, 1, 0);
        load = 1'b0; auto_reload = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("zero_rl_%0d", i), 0, 1, 1);
        end
        en = 1'b0;
        tick();
        expect_out("zero_rl_drop", 0, 1, 0);

        // Clear forgets the preset: reload after clear is all-ones
        load = 1'b1; d = 3'd3;
        tick();
        chk("load3", int'(q), 3);
        load = 1'b0;
        clr_pulse();
        chk("clr_after_load", int'(q), 7);
        auto_reload = 1'b1; en = 1'b1;
        repeat (7) tick();
        expect_out("count_to_0", 0, 1, 0);
        tick();
        expect_out("reload_after_clr", 7, 0, 1);
        en = 1'b0;
        tick();
        expect_out("final_idle", 7, 0, 0);

        cmp_on = 1'b0;
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
